// File: rtl/fp_32_vec_packer.sv
// Packs a framed scalar FP32 stream into OP_NUM-lane vectors for the compare tree.
// Incomplete final vectors are padded with PAD_VALUE (-inf) so padding never wins a max.
module fp_32_vec_packer #(
  parameter int OP_NUM = 4,
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE = 32'hFF80_0000,
  parameter int CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [OP_NUM*DATA_WIDTH-1:0] vec_data,
  output logic                         vec_valid,
  output logic                         row_done,
  output logic [CNT_WIDTH-1:0]         row_vec_cnt
);

  localparam int LW = (OP_NUM > 1) ? $clog2(OP_NUM) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(OP_NUM - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t                       state, next_state;
  logic [DATA_WIDTH-1:0]        lanes [OP_NUM];
  logic [LW-1:0]                lane_idx;
  logic [CNT_WIDTH-1:0]         count;
  logic                         accept;
  logic                         complete;
  logic [OP_NUM*DATA_WIDTH-1:0] next_vec;

  // The tree never backpressures, so readiness is just the shared stall.
  assign in_ready = en;
  assign accept   = in_valid & en;
  assign complete = accept & (in_last | (lane_idx == LAST_LANE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (en) begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && !in_last) next_state = FILL;
      FILL:    if (accept && in_last)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Completing element goes straight into its lane of the output, bypassing the lane registers.
  always_comb begin
    next_vec = '0;
    for (int k = 0; k < OP_NUM; k++) begin
      if (LW'(k) < lane_idx) begin
        next_vec[k*DATA_WIDTH +: DATA_WIDTH] = lanes[k];
      end else if (LW'(k) == lane_idx) begin
        next_vec[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
      end else begin
        next_vec[k*DATA_WIDTH +: DATA_WIDTH] = PAD_VALUE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < OP_NUM; k++) begin
        lanes[k] <= PAD_VALUE;
      end
      lane_idx    <= '0;
      count       <= '0;
      vec_data    <= {OP_NUM{PAD_VALUE}};
      vec_valid   <= 1'b0;
      row_done    <= 1'b0;
      row_vec_cnt <= '0;
    end else if (en) begin
      if (complete) begin
        for (int k = 0; k < OP_NUM; k++) begin
          lanes[k] <= PAD_VALUE;
        end
        lane_idx  <= '0;
        vec_data  <= next_vec;
        vec_valid <= 1'b1;
        if (in_last) begin
          row_done    <= 1'b1;
          row_vec_cnt <= count + CNT_WIDTH'(1);
          count       <= '0;
        end else begin
          row_done <= 1'b0;
          count    <= count + CNT_WIDTH'(1);
        end
      end else begin
        if (accept) begin
          lanes[lane_idx] <= in_data;
          lane_idx        <= lane_idx + LW'(1);
        end
        vec_valid <= 1'b0;
        row_done  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_32_vec_packer.sv
// Self-checking bench for fp_32_vec_packer: directed scenarios plus random traffic,
// compared each cycle against a queue-based model of row/vector framing.
module tb_fp_32_vec_packer;

  localparam int OP_NUM = 4;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam logic [DW-1:0] PAD = 32'hFF80_0000;

  logic                 clk;
  logic                 rst_n;
  logic                 en;
  logic [DW-1:0]        in_data;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic [OP_NUM*DW-1:0] vec_data;
  logic                 vec_valid;
  logic                 row_done;
  logic [CW-1:0]        row_vec_cnt;

  fp_32_vec_packer #(.OP_NUM(OP_NUM), .DATA_WIDTH(DW), .PAD_VALUE(PAD), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .vec_data(vec_data), .vec_valid(vec_valid),
    .row_done(row_done), .row_vec_cnt(row_vec_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: elements of the vector being built, and vectors issued so far in the row.
  logic [DW-1:0]        row_q[$];
  int                   vecs_in_row;
  logic                 exp_valid;
  logic                 exp_done;
  logic [CW-1:0]        exp_cnt;
  logic [OP_NUM*DW-1:0] exp_vec;

  task automatic model_reset();
    row_q.delete();
    vecs_in_row = 0;
    exp_valid = 1'b0;
    exp_done = 1'b0;
    exp_cnt = '0;
    for (int k = 0; k < OP_NUM; k++) exp_vec[k*DW +: DW] = PAD;
  endtask

  task automatic model_step(input bit e, input bit v, input logic [DW-1:0] d, input bit l);
    if (!e) return;
    exp_valid = 1'b0;
    exp_done = 1'b0;
    if (v) begin
      row_q.push_back(d);
      if (row_q.size() == OP_NUM || l) begin
        for (int k = 0; k < OP_NUM; k++)
          exp_vec[k*DW +: DW] = (k < row_q.size()) ? row_q[k] : PAD;
        row_q.delete();
        exp_valid = 1'b1;
        vecs_in_row++;
        if (l) begin
          exp_done = 1'b1;
          exp_cnt = CW'(vecs_in_row);
          vecs_in_row = 0;
        end
      end
    end
  endtask

  // Drive one clock cycle; outputs are then observed 1 time unit after the edge.
  task automatic cycle(input bit e, input bit v, input logic [DW-1:0] d, input bit l);
    en = e; in_valid = v; in_data = d; in_last = l;
    @(posedge clk);
    model_step(e, v, d, l);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b1; in_data = 32'h1234_5678; in_last = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({vec_valid, row_done, row_vec_cnt, vec_data} !== {exp_valid, exp_done, exp_cnt, exp_vec}) begin
      bad++;
      $display("[TB] FAIL reset_state: got v=%0b d=%0b c=%0d data=%h, want v=%0b d=%0b c=%0d data=%h",
               vec_valid, row_done, row_vec_cnt, vec_data, exp_valid, exp_done, exp_cnt, exp_vec);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_in_ready: got %0b want 1", in_ready);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_full_row();
    logic [DW-1:0] vals [8] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                                32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
    for (int i = 0; i < 9; i++) begin
      if (i < 8) cycle(1, 1, vals[i], i == 7);
      else       cycle(1, 0, 32'h0, 0);
      total++;
      if ({vec_valid, row_done, row_vec_cnt, vec_data} !== {exp_valid, exp_done, exp_cnt, exp_vec}) begin
        bad++;
        $display("[TB] FAIL full_row[%0d]: got v=%0b d=%0b c=%0d data=%h, want v=%0b d=%0b c=%0d data=%h",
                 i, vec_valid, row_done, row_vec_cnt, vec_data, exp_valid, exp_done, exp_cnt, exp_vec);
      end
    end
    total++;
    if (vec_data !== {32'h4100_0000, 32'h40E0_0000, 32'h40C0_0000, 32'h40A0_0000} || row_vec_cnt !== 16'd2) begin
      bad++;
      $display("[TB] FAIL full_row_final: got data=%h c=%0d want second vector 5..8 c=2", vec_data, row_vec_cnt);
    end
  endtask

  task automatic test_partial_row();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) cycle(1, 1, (i == 4) ? 32'h40A0_0000 : 32'h3F80_0000 + DW'(i), i == 4);
      else       cycle(1, 0, 32'h0, 0);
      total++;
      if ({vec_valid, row_done, row_vec_cnt, vec_data} !== {exp_valid, exp_done, exp_cnt, exp_vec}) begin
        bad++;
        $display("[TB] FAIL partial_row[%0d]: got v=%0b d=%0b c=%0d data=%h, want v=%0b d=%0b c=%0d data=%h",
                 i, vec_valid, row_done, row_vec_cnt, vec_data, exp_valid, exp_done, exp_cnt, exp_vec);
      end
    end
    total++;
    if (vec_data !== {PAD, PAD, PAD, 32'h40A0_0000} || row_vec_cnt !== 16'd2) begin
      bad++;
      $display("[TB] FAIL partial_row_final: got data=%h c=%0d want padded 5.0 c=2", vec_data, row_vec_cnt);
    end
  endtask

  task automatic test_single();
    cycle(1, 1, 32'hC0490FDB, 1);
    total++;
    if ({vec_valid, row_done, row_vec_cnt, vec_data} !== {1'b1, 1'b1, 16'd1, PAD, PAD, PAD, 32'hC0490FDB}) begin
      bad++;
      $display("[TB] FAIL single: got v=%0b d=%0b c=%0d data=%h, want v=1 d=1 c=1 data={pad,pad,pad,c0490fdb}",
               vec_valid, row_done, row_vec_cnt, vec_data);
    end
    cycle(1, 0, 32'h0, 0);
    total++;
    if ({vec_valid, row_done, row_vec_cnt, vec_data} !== {exp_valid, exp_done, exp_cnt, exp_vec}) begin
      bad++;
      $display("[TB] FAIL single_idle: got v=%0b d=%0b c=%0d data=%h, want v=%0b d=%0b c=%0d data=%h",
               vec_valid, row_done, row_vec_cnt, vec_data, exp_valid, exp_done, exp_cnt, exp_vec);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) cycle(1, 1, 32'h4200_0000 + DW'(i), 0);
    for (int i = 0; i < 3; i++) begin
      en = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_last = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL stall_in_ready[%0d]: got %0b want 0", i, in_ready);
      end
      cycle(0, 1, 32'hDEAD_BEEF, 1);
      total++;
      if ({vec_valid, row_done, row_vec_cnt, vec_data} !== {exp_valid, exp_done, exp_cnt, exp_vec}) begin
        bad++;
        $display("[TB] FAIL stall_hold[%0d]: got v=%0b d=%0b c=%0d data=%h, want v=%0b d=%0b c=%0d data=%h",
                 i, vec_valid, row_done, row_vec_cnt, vec_data, exp_valid, exp_done, exp_cnt, exp_vec);
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (i < 4) cycle(1, 1, 32'h4300_0000 + DW'(i), i == 3);
      else       cycle(1, 0, 32'h0, 0);
      total++;
      if ({vec_valid, row_done, row_vec_cnt, vec_data} !== {exp_valid, exp_done, exp_cnt, exp_vec}) begin
        bad++;
        $display("[TB] FAIL stall_resume[%0d]: got v=%0b d=%0b c=%0d data=%h, want v=%0b d=%0b c=%0d data=%h",
                 i, vec_valid, row_done, row_vec_cnt, vec_data, exp_valid, exp_done, exp_cnt, exp_vec);
      end
    end
  endtask

  task automatic test_reset_midrow();
    cycle(1, 1, 32'h4400_0000, 0);
    cycle(1, 1, 32'h4400_0001, 0);
    en = 1'b1; in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({vec_valid, row_done, row_vec_cnt, vec_data} !== {exp_valid, exp_done, exp_cnt, exp_vec}) begin
      bad++;
      $display("[TB] FAIL async_reset: got v=%0b d=%0b c=%0d data=%h, want v=%0b d=%0b c=%0d data=%h",
               vec_valid, row_done, row_vec_cnt, vec_data, exp_valid, exp_done, exp_cnt, exp_vec);
    end
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 32'h4500_0000 + DW'(i), i == 3);
      total++;
      if ({vec_valid, row_done, row_vec_cnt, vec_data} !== {exp_valid, exp_done, exp_cnt, exp_vec}) begin
        bad++;
        $display("[TB] FAIL reset_midrow[%0d]: got v=%0b d=%0b c=%0d data=%h, want v=%0b d=%0b c=%0d data=%h",
                 i, vec_valid, row_done, row_vec_cnt, vec_data, exp_valid, exp_done, exp_cnt, exp_vec);
      end
    end
    total++;
    if (row_vec_cnt !== 16'd1 || vec_data !== {32'h4500_0003, 32'h4500_0002, 32'h4500_0001, 32'h4500_0000}) begin
      bad++;
      $display("[TB] FAIL reset_midrow_clean: got data=%h c=%0d want clean 4-lane vector c=1", vec_data, row_vec_cnt);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      if (i < 4)      cycle(1, 1, 32'h4600_0000 + DW'(i), i == 3);
      else if (i < 7) cycle(1, 1, 32'h4700_0000 + DW'(i), i == 6);
      else            cycle(1, 0, 32'h0, 0);
      total++;
      if ({vec_valid, row_done, row_vec_cnt, vec_data} !== {exp_valid, exp_done, exp_cnt, exp_vec}) begin
        bad++;
        $display("[TB] FAIL back_to_back[%0d]: got v=%0b d=%0b c=%0d data=%h, want v=%0b d=%0b c=%0d data=%h",
                 i, vec_valid, row_done, row_vec_cnt, vec_data, exp_valid, exp_done, exp_cnt, exp_vec);
      end
    end
    total++;
    if (vec_data[3*DW +: DW] !== PAD || row_vec_cnt !== 16'd1) begin
      bad++;
      $display("[TB] FAIL back_to_back_pad: got lane3=%h c=%0d want lane3=ff800000 c=1", vec_data[3*DW +: DW], row_vec_cnt);
    end
  endtask

  task automatic test_random();
    bit e, v, l;
    logic [DW-1:0] d;
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 5) != 0);
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 4) == 0);
      d = $urandom;
      cycle(e, v, d, l);
      total++;
      if ({vec_valid, row_done, row_vec_cnt, vec_data} !== {exp_valid, exp_done, exp_cnt, exp_vec}) begin
        bad++;
        $display("[TB] FAIL random[%0d]: got v=%0b d=%0b c=%0d data=%h, want v=%0b d=%0b c=%0d data=%h",
                 i, vec_valid, row_done, row_vec_cnt, vec_data, exp_valid, exp_done, exp_cnt, exp_vec);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    #1;
    test_reset();
    test_full_row();
    test_partial_row();
    test_single();
    test_stall();
    test_reset_midrow();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
